// File: rtl/move_sequencer_if.sv
// Bus between the 2048 move sequencer and the 16-box register bank.
// Master is the sequencer; slave is the box bank / direction source.
interface move_sequencer_if;
    logic [3:0]  dir;
    logic [63:0] board_in;
    logic [63:0] board_out;
    logic        load;
    logic        busy;
    logic [1:0]  end_status;

    modport master (
        input  dir,
        input  board_in,
        output board_out,
        output load,
        output busy,
        output end_status
    );

    modport slave (
        output dir,
        output board_in,
        input  board_out,
        input  load,
        input  busy,
        input  end_status
    );
endinterface

// File: rtl/move_sequencer.sv
// 2048 move sequencer: seeds two tiles after reset, then for each one-hot
// direction press slides/merges one line per cycle, spawns a tile at a
// pseudo-random empty cell, commits the board to the boxes and checks win/loss.
// Cell i (row*4+col) lives in bits [63-4i:60-4i]; value is a 4-bit exponent.
module move_sequencer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned WIN_EXP   = 11
) (
    input logic              clock,
    input logic              resetn,
    move_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StInit1,
        StInit2,
        StIdle,
        StSlide,
        StCompare,
        StSpawn,
        StCommit,
        StCheck,
        StOver
    } state_t;

    state_t      r_state;
    logic [63:0] r_work;
    logic [63:0] r_board_out;
    logic        r_load;
    logic [1:0]  r_end_status;
    logic [15:0] r_lfsr;
    logic [3:0]  r_dir_prev;
    logic [3:0]  r_dir;
    logic [1:0]  r_line;
    logic [3:0]  r_idx;
    logic [3:0]  r_scan_cnt;

    logic [15:0] w_lfsr_next;
    logic        w_dir_onehot;
    logic        w_trigger;
    logic [3:0]  w_pos [4];
    logic [15:0] w_line_in;
    logic [15:0] w_line_out;
    logic [63:0] w_work_slid;
    logic        w_idx_empty;
    logic [3:0]  w_tile;
    logic [63:0] w_spawn_next;
    logic        w_scan_done;
    logic        w_won;
    logic        w_has_empty;
    logic        w_has_pair;
    logic        w_lost;

    // Bit offset of cell i is 4*(15-i), i.e. {~i, 2'b00}.
    function automatic logic [3:0] get_cell(input logic [63:0] b, input logic [3:0] i);
        return b[{~i, 2'b00} +: 4];
    endfunction

    // Cell index of position p in line k, position 0 being the edge moved toward.
    function automatic logic [3:0] line_cell(input logic [3:0] d, input logic [1:0] k,
                                             input logic [1:0] p);
        if (d[3]) begin
            return {p, k};
        end else if (d[2]) begin
            return {~p, k};
        end else if (d[0]) begin
            return {k, ~p};
        end else begin
            return {k, p};
        end
    endfunction

    // Pack nonzero entries toward position 0, preserving order.
    function automatic logic [15:0] compact(input logic [15:0] l);
        logic [15:0] o;
        int          j;
        o = '0;
        j = 0;
        for (int i = 0; i < 4; i++) begin
            if (l[4*i +: 4] != 4'd0) begin
                o[4*j +: 4] = l[4*i +: 4];
                j++;
            end
        end
        return o;
    endfunction

    // Merge equal adjacent pairs once, scanning from position 0; the cleared
    // partner can never match again, so no tile merges twice.
    function automatic logic [15:0] merge_line(input logic [15:0] l);
        logic [15:0] o;
        o = l;
        for (int i = 0; i < 3; i++) begin
            if (o[4*i +: 4] != 4'd0 && o[4*i +: 4] == o[4*(i+1) +: 4]) begin
                o[4*i +: 4]     = (o[4*i +: 4] == 4'hF) ? 4'hF : o[4*i +: 4] + 4'd1;
                o[4*(i+1) +: 4] = 4'd0;
            end
        end
        return o;
    endfunction

    // Galois LFSR x^16+x^14+x^13+x^11 and press detection.
    always_comb begin
        w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_dir_onehot = (bus.dir != 4'd0) && ((bus.dir & (bus.dir - 4'd1)) == 4'd0);
        w_trigger    = (r_state == StIdle) && (r_dir_prev == 4'd0) && w_dir_onehot;
    end

    // Slide and merge the current line of the work board.
    always_comb begin
        w_line_in = '0;
        for (int p = 0; p < 4; p++) begin
            w_pos[p]            = line_cell(r_dir, r_line, 2'(p));
            w_line_in[4*p +: 4] = get_cell(r_work, w_pos[p]);
        end
        w_line_out  = compact(merge_line(compact(w_line_in)));
        w_work_slid = r_work;
        for (int p = 0; p < 4; p++) begin
            w_work_slid[{~w_pos[p], 2'b00} +: 4] = w_line_out[4*p +: 4];
        end
    end

    // One step of the spawn scan at cell r_idx.
    always_comb begin
        w_idx_empty  = (get_cell(r_work, r_idx) == 4'd0);
        w_tile       = (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
        w_spawn_next = r_work;
        if (w_idx_empty) begin
            w_spawn_next[{~r_idx, 2'b00} +: 4] = w_tile;
        end
        w_scan_done  = w_idx_empty || (r_scan_cnt == 4'd15);
    end

    // Win/loss evaluation on the work board.
    always_comb begin
        w_won       = 1'b0;
        w_has_empty = 1'b0;
        w_has_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ({28'd0, get_cell(r_work, 4'(i))} >= WIN_EXP) w_won = 1'b1;
            if (get_cell(r_work, 4'(i)) == 4'd0) w_has_empty = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (get_cell(r_work, 4'(r*4 + c)) == get_cell(r_work, 4'(r*4 + c + 1)))
                    w_has_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (get_cell(r_work, 4'(r*4 + c)) == get_cell(r_work, 4'(r*4 + c + 4)))
                    w_has_pair = 1'b1;
            end
        end
        w_lost = !w_has_empty && !w_has_pair;
    end

    // Move sequencing FSM with registered board/load/status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StInit1;
            r_work       <= '0;
            r_board_out  <= '0;
            r_load       <= 1'b0;
            r_end_status <= 2'b00;
            r_lfsr       <= LFSR_SEED;
            r_dir_prev   <= 4'd0;
            r_dir        <= 4'd0;
            r_line       <= 2'd0;
            r_idx        <= LFSR_SEED[3:0];
            r_scan_cnt   <= 4'd0;
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_dir_prev <= bus.dir;
            r_load     <= 1'b0;
            unique case (r_state)
                StInit1, StInit2, StSpawn: begin
                    r_work <= w_spawn_next;
                    if (w_scan_done) begin
                        r_scan_cnt <= 4'd0;
                        if (r_state == StInit1) begin
                            r_idx   <= r_lfsr[3:0];
                            r_state <= StInit2;
                        end else begin
                            // load goes high for the COMMIT cycle only
                            r_board_out <= w_spawn_next;
                            r_load      <= 1'b1;
                            r_state     <= StCommit;
                        end
                    end else begin
                        r_idx      <= r_idx + 4'd1;
                        r_scan_cnt <= r_scan_cnt + 4'd1;
                    end
                end
                StIdle: begin
                    if (w_trigger) begin
                        r_work  <= bus.board_in;
                        r_dir   <= bus.dir;
                        r_line  <= 2'd0;
                        r_state <= StSlide;
                    end
                end
                StSlide: begin
                    r_work <= w_work_slid;
                    r_line <= r_line + 2'd1;
                    if (r_line == 2'd3) r_state <= StCompare;
                end
                StCompare: begin
                    if (r_work == bus.board_in) begin
                        r_state <= StIdle;
                    end else begin
                        r_idx      <= r_lfsr[3:0];
                        r_scan_cnt <= 4'd0;
                        r_state    <= StSpawn;
                    end
                end
                StCommit: begin
                    r_state <= StCheck;
                end
                StCheck: begin
                    if (w_won) begin
                        r_end_status <= 2'b01;
                        r_state      <= StOver;
                    end else if (w_lost) begin
                        r_end_status <= 2'b10;
                        r_state      <= StOver;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StOver: begin
                    r_state <= StOver;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.board_out  = r_board_out;
    assign bus.load       = r_load;
    assign bus.end_status = r_end_status;
    assign bus.busy       = (r_state != StIdle) && (r_state != StOver);

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: models the 16-box bank, applies a table of
// directed moves with hand-computed slide results, plus hand-written
// sequences for no-move timing, held/multi-bit presses, win and async reset.
module tb_move_sequencer;

    logic clock = 1'b0;
    logic resetn;
    move_sequencer_if bus ();

    logic [63:0] boxes;
    logic        pre_req;
    logic [63:0] pre_val;
    int          n_tests;
    int          n_fail;

    always #5 clock = ~clock;

    move_sequencer #(
        .LFSR_SEED (16'hACE1),
        .WIN_EXP   (11)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    assign bus.board_in = boxes;

    // Box bank: cleared by reset, written on load, or preloaded by the bench.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) boxes <= '0;
        else if (bus.load) boxes <= bus.board_out;
        else if (pre_req) boxes <= pre_val;
    end

    typedef struct {
        string       name;
        logic [63:0] board;
        logic [3:0]  dir;
        logic [63:0] slid;
        logic        moved;
        logic [1:0]  status;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (bus.busy && i < 200) begin
            @(negedge clock);
            i++;
        end
        check({name, " idle"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn  = 1'b0;
        bus.dir = 4'd0;
        pre_req = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic preload(input logic [63:0] b);
        pre_val = b;
        pre_req = 1'b1;
        @(negedge clock);
        pre_req = 1'b0;
    endtask

    // Counts nonzero cells and checks they are all 1 or 2.
    task automatic check_init(input string name);
        int lat, loads, nz, bad;
        logic [3:0] a;
        lat = -1;
        loads = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (bus.load) begin
                loads++;
                if (lat < 0) lat = k;
            end
        end
        nz = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            a = boxes[60 - 4*i +: 4];
            if (a != 4'd0) begin
                nz++;
                if (a != 4'd1 && a != 4'd2) bad++;
            end
        end
        check({name, " loads"}, 64'(loads), 64'd1);
        check({name, " latency"}, {63'd0, (lat >= 1 && lat <= 34)}, 64'd1);
        check({name, " tiles"}, 64'(nz), 64'd2);
        check({name, " tile values"}, 64'(bad), 64'd0);
        check({name, " busy"}, {63'd0, bus.busy}, 64'd0);
        check({name, " status"}, {62'd0, bus.end_status}, 64'd0);
    endtask

    // Drives d at the current negedge; releases at negedge `hold`.
    task automatic apply_move(input logic [3:0] d, input int hold,
                              output int lat, output int loads, output int busy_cnt);
        bus.dir = d;
        lat = -1;
        loads = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == hold) bus.dir = 4'd0;
            if (bus.busy) busy_cnt++;
            if (bus.load) begin
                loads++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    // Nonzero expected cells must match; exactly one previously empty cell gains 1 or 2.
    task automatic check_board(input string name, input logic [63:0] exp);
        int kept_bad, spawned, spawn_bad;
        logic [3:0] a, e;
        kept_bad = 0;
        spawned = 0;
        spawn_bad = 0;
        for (int i = 0; i < 16; i++) begin
            a = boxes[60 - 4*i +: 4];
            e = exp[60 - 4*i +: 4];
            if (e != 4'd0) begin
                if (a != e) kept_bad++;
            end else if (a != 4'd0) begin
                spawned++;
                if (a != 4'd1 && a != 4'd2) spawn_bad++;
            end
        end
        check({name, " kept cells"}, 64'(kept_bad), 64'd0);
        check({name, " spawn count"}, 64'(spawned), 64'd1);
        check({name, " spawn value"}, 64'(spawn_bad), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, loads, busy_cnt;
        int busy5, busy6;

        vecs[0] = '{"left 1122",  64'h1122_0000_0000_0000, 4'b0010, 64'h2300_0000_0000_0000, 1'b1, 2'b00};
        vecs[1] = '{"right 0202", 64'h0202_0000_0000_0000, 4'b0001, 64'h0003_0000_0000_0000, 1'b1, 2'b00};
        vecs[2] = '{"up col0",    64'h1000_0000_1000_0000, 4'b1000, 64'h2000_0000_0000_0000, 1'b1, 2'b00};
        vecs[3] = '{"left 1111",  64'h0000_1111_0000_0000, 4'b0010, 64'h0000_2200_0000_0000, 1'b1, 2'b00};
        vecs[4] = '{"down col2",  64'h0020_0000_0020_0020, 4'b0100, 64'h0000_0000_0020_0030, 1'b1, 2'b00};
        vecs[5] = '{"right 1120", 64'h0000_0000_1120_0000, 4'b0001, 64'h0000_0000_0022_0000, 1'b1, 2'b00};
        vecs[6] = '{"left none",  64'h1200_0000_0000_0000, 4'b0010, 64'h1200_0000_0000_0000, 1'b0, 2'b00};
        vecs[7] = '{"right none", 64'h0012_0000_0000_0000, 4'b0001, 64'h0012_0000_0000_0000, 1'b0, 2'b00};
        vecs[8] = '{"lost",       64'h0345_4536_3453_4534, 4'b0010, 64'h3450_4536_3453_4534, 1'b1, 2'b10};

        n_tests = 0;
        n_fail  = 0;
        pre_req = 1'b0;
        pre_val = '0;
        bus.dir = 4'd0;
        resetn  = 1'b0;

        #1;
        check("reset board_out", bus.board_out, 64'd0);
        check("reset load", {63'd0, bus.load}, 64'd0);
        check("reset status", {62'd0, bus.end_status}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd1);

        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check_init("init");

        for (int v = 0; v < NV; v++) begin
            wait_idle(vecs[v].name);
            preload(vecs[v].board);
            apply_move(vecs[v].dir, 2, lat, loads, busy_cnt);
            if (vecs[v].moved) begin
                check({vecs[v].name, " loads"}, 64'(loads), 64'd1);
                check({vecs[v].name, " latency"}, {63'd0, (lat >= 7 && lat <= 22)}, 64'd1);
                check_board(vecs[v].name, vecs[v].slid);
            end else begin
                check({vecs[v].name, " loads"}, 64'(loads), 64'd0);
                check({vecs[v].name, " board"}, boxes, vecs[v].board);
            end
            check({vecs[v].name, " status"}, {62'd0, bus.end_status}, {62'd0, vecs[v].status});
            check({vecs[v].name, " busy"}, {63'd0, bus.busy}, 64'd0);
            if (vecs[v].status != 2'b00) begin
                do_reset();
                check_init({vecs[v].name, " reinit"});
            end
        end

        // No legal move: back in IDLE exactly at T+6.
        wait_idle("nomove timing");
        preload(64'h1200_0000_0000_0000);
        bus.dir = 4'b0010;
        busy5 = 0;
        busy6 = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 2) bus.dir = 4'd0;
            if (k == 5) busy5 = int'(bus.busy);
            if (k == 6) busy6 = int'(bus.busy);
        end
        check("nomove busy T+5", 64'(busy5), 64'd1);
        check("nomove busy T+6", 64'(busy6), 64'd0);

        // Held press triggers once; two bits never trigger.
        wait_idle("hold");
        preload(64'h1100_0000_0000_0000);
        apply_move(4'b0010, 50, lat, loads, busy_cnt);
        check("hold loads", 64'(loads), 64'd1);
        wait_idle("multibit");
        preload(64'h1100_0000_0000_0000);
        apply_move(4'b0011, 10, lat, loads, busy_cnt);
        check("multibit loads", 64'(loads), 64'd0);
        check("multibit busy", 64'(busy_cnt), 64'd0);

        // Win, then later presses ignored.
        wait_idle("win");
        preload(64'hAA00_0000_0000_0000);
        apply_move(4'b0010, 2, lat, loads, busy_cnt);
        check("win loads", 64'(loads), 64'd1);
        check("win cell0", {60'd0, boxes[63:60]}, 64'd11);
        check("win status", {62'd0, bus.end_status}, 64'd1);
        apply_move(4'b1000, 2, lat, loads, busy_cnt);
        check("over loads", 64'(loads), 64'd0);
        check("over busy", 64'(busy_cnt), 64'd0);
        check("over status", {62'd0, bus.end_status}, 64'd1);

        do_reset();
        check_init("post win init");

        // Asynchronous reset during SPAWN (state after edge T+6).
        wait_idle("spawn reset");
        preload(64'h1100_0000_0000_0000);
        bus.dir = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 2) bus.dir = 4'd0;
        end
        check("pre-reset board_out nonzero", {63'd0, (bus.board_out != 64'd0)}, 64'd1);
        resetn = 1'b0;
        #1;
        check("async board_out", bus.board_out, 64'd0);
        check("async load", {63'd0, bus.load}, 64'd0);
        check("async status", {62'd0, bus.end_status}, 64'd0);
        check("async busy", {63'd0, bus.busy}, 64'd1);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        check_init("rerun init");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
